// File: rtl/err_accum_pkg.sv
// Shared types and parameter defaults for the error accumulator.
package err_accum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_ACCUM,
    ST_WAIT,
    ST_DRAIN
  } state_e;

  typedef enum logic {
    MODE_MSE = 1'b0,
    MODE_MAX = 1'b1
  } mode_e;

  localparam int NUM_CH_DEF  = 3;
  localparam int DW_DEF      = 29;
  localparam int LOG2_N_DEF  = 10;
  localparam int DISCARD_DEF = 8;
  localparam int OW_DEF      = 64;

  // Cycles spent in WAIT; equals the lane pipeline depth (diff, magnitude).
  localparam int WAIT_CYC = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/err_lane.sv
// One channel: difference, square or magnitude, accumulate or track max,
// then shift/saturate to the result width.
module err_lane
  import err_accum_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int LOG2_N = LOG2_N_DEF,
  parameter int OW     = OW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  mode_e         mode,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] dref,
  output logic [OW-1:0] res
);

  localparam int AW   = DW + 1;
  localparam int MW   = 2 * DW + 2;
  localparam int ACCW = MW + LOG2_N;

  logic signed [AW-1:0] diff_q, diff_d;
  logic [MW-1:0]        mag_q, mag_d;
  logic [ACCW-1:0]      acc_q, acc_d;
  logic [1:0]           vld_pipe_q, vld_pipe_d;
  logic [AW-1:0]        abs_w;
  logic [MW-1:0]        abs_ext;
  logic [ACCW-1:0]      mag_ext;
  logic [ACCW-1:0]      r;

  // Two-stage datapath feeding the accumulator; clr wipes the whole lane.
  always_comb begin
    diff_d     = $signed({din[DW-1], din}) - $signed({dref[DW-1], dref});
    abs_w      = diff_q[AW-1] ? AW'(-diff_q) : AW'(diff_q);
    abs_ext    = MW'(abs_w);
    mag_d      = (mode == MODE_MAX) ? abs_ext : abs_ext * abs_ext;
    vld_pipe_d = {vld_pipe_q[0], en};
    mag_ext    = ACCW'(mag_q);
    acc_d      = acc_q;
    if (vld_pipe_q[1]) begin
      if (mode == MODE_MAX) acc_d = (mag_ext > acc_q) ? mag_ext : acc_q;
      else                  acc_d = acc_q + mag_ext;
    end
    if (clr) begin
      diff_d     = '0;
      mag_d      = '0;
      acc_d      = '0;
      vld_pipe_d = '0;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q     <= '0;
      mag_q      <= '0;
      acc_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      diff_q     <= diff_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // MSE divides by N with truncation; max mode reports the running peak.
  always_comb begin
    r = (mode == MODE_MSE) ? (acc_q >> LOG2_N) : acc_q;
  end

  if (OW > ACCW) begin : g_zext
    assign res = {{(OW - ACCW){1'b0}}, r};
  end else if (OW == ACCW) begin : g_eq
    assign res = r;
  end else begin : g_sat
    assign res = (|r[ACCW-1:OW]) ? {OW{1'b1}} : r[OW-1:0];
  end

endmodule

// File: rtl/err_accum.sv
// Multi-channel error accumulator: FSM, sample counters, result drain mux.
module err_accum
  import err_accum_pkg::*;
#(
  parameter int  NUM_CH  = NUM_CH_DEF,
  parameter int  DW      = DW_DEF,
  parameter int  LOG2_N  = LOG2_N_DEF,
  parameter int  DISCARD = DISCARD_DEF,
  parameter int  OW      = OW_DEF,
  localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 in_valid,
  input  logic [NUM_CH*DW-1:0] data_in,
  input  logic [NUM_CH*DW-1:0] data_ref,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OW-1:0]        res_data,
  output logic [CHW-1:0]       res_ch,
  output logic                 busy
);

  localparam int CW = max2(max2($clog2(DISCARD + 1), LOG2_N + 1), 2);
  localparam logic [CW-1:0]  DISC_LAST = CW'(DISCARD - 1);
  localparam logic [CW-1:0]  N_LAST    = CW'((1 << LOG2_N) - 1);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(WAIT_CYC - 1);
  localparam logic [CHW-1:0] CH_LAST   = CHW'(NUM_CH - 1);

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    res_valid_q, res_valid_d;
  logic [OW-1:0]           res_data_q, res_data_d;
  logic [CHW-1:0]          res_ch_q, res_ch_d;
  logic [CHW-1:0]          ch_nxt;
  logic                    lane_clr, lane_en;
  logic [NUM_CH-1:0][OW-1:0] lane_res;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    err_lane #(.DW(DW), .LOG2_N(LOG2_N), .OW(OW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (lane_clr),
      .en   (lane_en),
      .mode (mode_q),
      .din  (data_in[k*DW +: DW]),
      .dref (data_ref[k*DW +: DW]),
      .res  (lane_res[k])
    );
  end

  // Next-state logic; result word is registered one cycle after DRAIN entry
  // so the last accumulator update is visible before it is presented.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    lane_clr    = 1'b0;
    lane_en     = 1'b0;
    ch_nxt      = res_ch_q + CHW'(1);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d   = mode_e'(mode);
          cnt_d    = '0;
          lane_clr = 1'b1;
          state_d  = (DISCARD == 0) ? ST_ACCUM : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (in_valid) begin
          if (cnt_q == DISC_LAST) begin
            cnt_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          lane_en = 1'b1;
          if (cnt_q == N_LAST) begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_ch_d    = '0;
          res_data_d  = lane_res[0];
        end else if (res_ready) begin
          if (res_ch_q == CH_LAST) begin
            res_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            res_ch_d   = ch_nxt;
            res_data_d = lane_res[ch_nxt];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_MSE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_err_accum.sv
// Randomised scoreboard bench for err_accum (2 channels, 8-bit, N=4, 3 discards).
module tb_err_accum;

  localparam int NCH = 2;
  localparam int DW  = 8;
  localparam int L2N = 2;
  localparam int DSC = 3;
  localparam int N   = 1 << L2N;
  localparam int TOT = DSC + N;

  typedef struct {
    int          ch;
    logic [63:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, start, mode, in_valid, res_ready;
  logic [NCH*DW-1:0] data_in, data_ref;
  logic              res_valid, busy, res_valid8, busy8;
  logic [63:0]       res_data;
  logic [7:0]        res_data8;
  logic              res_ch, res_ch8;

  exp_t q64[$];
  exp_t q8[$];
  int   di[TOT][NCH];
  int   dr[TOT][NCH];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  err_accum #(.NUM_CH(NCH), .DW(DW), .LOG2_N(L2N), .DISCARD(DSC), .OW(64)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid),
    .data_in(data_in), .data_ref(data_ref), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch), .busy(busy)
  );

  err_accum #(.NUM_CH(NCH), .DW(DW), .LOG2_N(L2N), .DISCARD(DSC), .OW(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in_valid(in_valid),
    .data_in(data_in), .data_ref(data_ref), .res_valid(res_valid8),
    .res_ready(res_ready), .res_data(res_data8), .res_ch(res_ch8), .busy(busy8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result word is compared against the queue head.
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (q64.size() == 0) chk("unexpected_res64", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q64.pop_front();
        chk("res_ch64", 64'(res_ch), 64'(e.ch));
        chk("res_data64", res_data, e.data);
      end
    end
    if (res_valid8 && res_ready) begin
      if (q8.size() == 0) chk("unexpected_res8", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("res_ch8", 64'(res_ch8), 64'(e.ch));
        chk("res_data8", 64'(res_data8), e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: drop the first DSC samples, then mean of squares or peak |diff|.
  function automatic longint model(input bit md, input int k);
    longint s = 0;
    for (int i = DSC; i < TOT; i++) begin
      longint d = longint'(di[i][k]) - longint'(dr[i][k]);
      longint a = (d < 0) ? -d : d;
      if (md) s = (a > s) ? a : s;
      else    s = s + d * d;
    end
    return md ? s : s / N;
  endfunction

  task automatic junk();
    data_in  = (NCH*DW)'($urandom);
    data_ref = (NCH*DW)'($urandom);
  endtask

  // gap: 0 none, 1 one idle cycle before each sample, 2 random idles.
  task automatic feed(input bit md, input int gap, input int nfeed);
    start = 1'b1;
    mode  = md;
    tick();
    start = 1'b0;
    mode  = $urandom_range(1);
    for (int i = 0; i < nfeed; i++) begin
      if (gap == 1) begin
        in_valid = 1'b0; junk(); tick();
      end else if (gap == 2) begin
        while ($urandom_range(99) < 40) begin
          in_valid = 1'b0; junk(); tick();
        end
      end
      in_valid = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        data_in[k*DW +: DW]  = DW'(di[i][k]);
        data_ref[k*DW +: DW] = DW'(dr[i][k]);
      end
      tick();
    end
    in_valid = 1'($urandom_range(1));
    junk();
    if (nfeed == TOT) begin
      for (int k = 0; k < NCH; k++) begin
        longint v = model(md, k);
        q64.push_back('{k, 64'(v)});
        q8.push_back('{k, (v > 255) ? 64'd255 : 64'(v)});
      end
      chk("no_early_valid", 64'(res_valid), 64'd0);
    end
  endtask

  task automatic drain(input int rdy_pct);
    int cyc = 0;
    while ((busy || busy8) && cyc < 300) begin
      res_ready = ($urandom_range(99) < rdy_pct);
      in_valid  = 1'($urandom_range(1));
      junk();
      tick();
      cyc++;
    end
    res_ready = 1'b0;
    in_valid  = 1'b0;
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_busy8", 64'(busy8), 64'd0);
    chk("drain_valid", 64'(res_valid), 64'd0);
  endtask

  task automatic load_035();
    for (int i = 0; i < TOT; i++) begin
      int r0 = $urandom_range(200) - 100;
      int r1 = $urandom_range(200) - 100;
      if (i < DSC) begin
        di[i][0] = 100; dr[i][0] = 0;
        di[i][1] = 100; dr[i][1] = 0;
      end else begin
        di[i][0] = r0 + 3; dr[i][0] = r0;
        di[i][1] = r1 - 2; dr[i][1] = r1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    data_in = '0; data_ref = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_data", res_data, 64'd0);
    chk("rst_ch", 64'(res_ch), 64'd0);
    rst = 1'b0;
    tick();

    // Identical paths, MSE -> zeros.
    for (int i = 0; i < TOT; i++)
      for (int k = 0; k < NCH; k++) begin
        di[i][k] = $urandom_range(255) - 128;
        dr[i][k] = di[i][k];
      end
    feed(1'b0, 0, TOT);
    drain(100);

    // Flush samples excluded: ch0 -> 9, ch1 -> 4.
    load_035();
    feed(1'b0, 0, TOT);
    drain(60);

    // Max |diff| with contiguous and alternating in_valid.
    for (int g = 0; g < 2; g++) begin
      int dd[4] = '{1, -5, 2, 0};
      for (int i = 0; i < TOT; i++) begin
        dr[i][0] = $urandom_range(100) - 50;
        di[i][0] = (i < DSC) ? dr[i][0] + 60 : dr[i][0] + dd[i-DSC];
        di[i][1] = $urandom_range(255) - 128;
        dr[i][1] = $urandom_range(255) - 128;
      end
      feed(1'b1, g, TOT);
      drain(100);
    end

    // Extreme diff: 255^2 = 65025, saturates on the 8-bit result.
    for (int i = 0; i < TOT; i++) begin
      di[i][0] = 127; dr[i][0] = -128;
      di[i][1] = -128; dr[i][1] = 127;
    end
    feed(1'b0, 0, TOT);
    drain(100);

    // Back-pressure in DRAIN with a stray start; start on final handshake.
    load_035();
    feed(1'b0, 0, TOT);
    begin
      int cyc = 0;
      logic [63:0] d0;
      logic        c0;
      while (!res_valid && cyc < 20) begin tick(); cyc++; end
      chk("drain_reached", 64'(res_valid), 64'd1);
      d0 = res_data;
      c0 = res_ch;
      for (int j = 0; j < 5; j++) begin
        start = (j == 2);
        tick();
        start = 1'b0;
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_data", res_data, d0);
        chk("hold_ch", 64'(res_ch), 64'(c0));
      end
      cyc = 0;
      while (busy && cyc < 20) begin
        res_ready = 1'b1;
        start = res_valid && res_ch;
        tick();
        start = 1'b0;
        cyc++;
      end
      res_ready = 1'b0;
      tick(); tick();
      chk("start_ignored_busy", 64'(busy), 64'd0);
      chk("start_ignored_valid", 64'(res_valid), 64'd0);
    end

    // Reset mid-ACCUM aborts without a result; the rerun is clean.
    load_035();
    feed(1'b0, 0, DSC + 2);
    rst = 1'b1;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(res_valid), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    load_035();
    feed(1'b0, 0, TOT);
    drain(100);

    // Random measurements.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < TOT; i++)
        for (int k = 0; k < NCH; k++) begin
          di[i][k] = ($urandom_range(9) == 0) ? 127  : $urandom_range(255) - 128;
          dr[i][k] = ($urandom_range(9) == 0) ? -128 : $urandom_range(255) - 128;
        end
      feed(1'($urandom_range(1)), $urandom_range(2), TOT);
      drain($urandom_range(30, 100));
    end

    chk("q64_empty", 64'(q64.size()), 64'd0);
    chk("q8_empty", 64'(q8.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
